// File: rtl/spi_pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pwm_pkg
// Description : Shared constants, register map and FSM state type for the
//               SPI-controlled PWM register block.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pwm_pkg;

    localparam logic [7:0]  c_id_value      = 8'hA5;

    // Register map
    localparam logic [2:0]  c_addr_ctrl     = 3'd0;
    localparam logic [2:0]  c_addr_per_l    = 3'd1;
    localparam logic [2:0]  c_addr_per_h    = 3'd2;
    localparam logic [2:0]  c_addr_duty_l   = 3'd3;
    localparam logic [2:0]  c_addr_duty_h   = 3'd4;
    localparam logic [2:0]  c_addr_status   = 3'd5;
    localparam logic [2:0]  c_addr_id       = 3'd6;
    localparam logic [2:0]  c_addr_rsvd     = 3'd7;

    // CTRL bit positions
    localparam int          c_ctrl_en       = 0;
    localparam int          c_ctrl_ext_en   = 1;
    localparam int          c_ctrl_start    = 2;

    // Reset values of the PWM settings
    localparam logic [15:0] c_period_rst    = 16'h00FF;
    localparam logic [15:0] c_duty_rst      = 16'h0080;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_DATA  = 2'd2,
        ST_ABORT = 2'd3
    } state_t;

    // Duty may never exceed the period it is paired with.
    function automatic logic [15:0] sat_duty(input logic [15:0] duty,
                                             input logic [15:0] period);
        return (duty > period) ? period : duty;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_pwm_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_pwm_ctrl_if
// Description : Byte-level link between an SPI slave shifter and the
//               register block (chip-select, received byte, reply byte).
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_pwm_ctrl_if;
    logic       cs_active;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic [7:0] tx_byte;

    modport master (output cs_active, output rx_valid, output rx_byte, input  tx_byte);
    modport slave  (input  cs_active, input  rx_valid, input  rx_byte, output tx_byte);
endinterface
`default_nettype wire

// File: rtl/spi_pwm_ctrl_sync_rise.sv
`default_nettype none
// ============================================================================
// Module      : sync_rise
// Description : Two-flop synchroniser for an asynchronous input followed by
//               a rising-edge detector producing a one-cycle pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_rise
);
    // [0],[1] are the metastability chain, [2] holds the previous synced level
    logic [2:0] r_sync;

    // Shift the asynchronous level through the synchroniser chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 3'b000;
        end else begin
            r_sync <= {r_sync[1:0], i_async};
        end
    end

    assign o_rise = r_sync[1] & ~r_sync[2];
endmodule
`default_nettype wire

// File: rtl/spi_pwm_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spi_pwm_ctrl
// Description : SPI byte-protocol register block configuring a PWM core.
//               Command byte selects read/write and start address, data
//               bytes auto-increment the address; period/duty are staged
//               and committed atomically.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_pwm_ctrl
    import spi_pwm_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    spi_pwm_ctrl_if.slave  spi,
    input  logic           pwm_start_ext,
    input  logic           pwm_period_end,
    output logic           pwm_en,
    output logic [15:0]    pwm_period,
    output logic [15:0]    pwm_duty,
    output logic           pwm_start,
    output logic           frame_err
);
    state_t      r_state, w_state_nxt;
    logic        r_cs_prev, r_is_write, r_ctrl_en, r_ctrl_ext, r_pending;
    logic        r_frame_err, r_start;
    logic [2:0]  r_addr, w_rd_addr;
    logic [7:0]  r_tx, w_rd_data;
    logic [15:0] r_stage_per, r_stage_duty, r_period, r_duty;
    logic [15:0] w_stage_per_nxt, w_stage_duty_nxt;
    logic        w_pending_nxt, w_commit, w_ext_rise;

    wire w_cs_rise   = spi.cs_active & ~r_cs_prev;
    wire w_cmd_ok    = (spi.rx_byte[6:3] == 4'd0);
    wire w_cmd_byte  = spi.cs_active & spi.rx_valid & (r_state == ST_CMD);
    wire w_data_byte = spi.cs_active & spi.rx_valid & (r_state == ST_DATA);
    wire w_wr        = w_data_byte & r_is_write;
    wire w_err_set   = w_cmd_byte & ~w_cmd_ok;
    wire w_ctrl_wr   = w_wr & (r_addr == c_addr_ctrl);
    wire w_spi_start = w_ctrl_wr & spi.rx_byte[c_ctrl_start]
                     & (spi.rx_byte[c_ctrl_en] | r_ctrl_en);
    wire w_ext_start = w_ext_rise & r_ctrl_en & r_ctrl_ext;

    sync_rise u_sync_ext (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (pwm_start_ext),
        .o_rise  (w_ext_rise)
    );

    // Frame state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Frame sequencing: chip-select loss always returns to IDLE
    always_comb begin
        w_state_nxt = r_state;
        if (!spi.cs_active) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_cs_rise) w_state_nxt = ST_CMD;
                ST_CMD: begin
                    if (spi.rx_valid) begin
                        if (w_cmd_ok) w_state_nxt = ST_DATA;
                        else          w_state_nxt = ST_ABORT;
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // Register readback mux; the command byte addresses directly, data bytes prefetch addr+1
    always_comb begin
        w_rd_addr = (r_state == ST_CMD) ? spi.rx_byte[2:0] : r_addr + 3'd1;
        case (w_rd_addr)
            c_addr_ctrl:   w_rd_data = {6'd0, r_ctrl_ext, r_ctrl_en};
            c_addr_per_l:  w_rd_data = r_stage_per[7:0];
            c_addr_per_h:  w_rd_data = r_stage_per[15:8];
            c_addr_duty_l: w_rd_data = r_stage_duty[7:0];
            c_addr_duty_h: w_rd_data = r_stage_duty[15:8];
            c_addr_status: w_rd_data = {5'd0, r_pending, r_frame_err, r_ctrl_en};
            c_addr_id:     w_rd_data = c_id_value;
            default:       w_rd_data = 8'h00;
        endcase
    end

    // Staging updates and commit decision; a high-byte write with EN clear commits at once
    always_comb begin
        w_stage_per_nxt  = r_stage_per;
        w_stage_duty_nxt = r_stage_duty;
        w_pending_nxt    = r_pending;
        if (w_wr) begin
            case (r_addr)
                c_addr_per_l:  w_stage_per_nxt[7:0]   = spi.rx_byte;
                c_addr_per_h:  begin
                    w_stage_per_nxt[15:8]  = spi.rx_byte;
                    w_pending_nxt          = 1'b1;
                end
                c_addr_duty_l: w_stage_duty_nxt[7:0]  = spi.rx_byte;
                c_addr_duty_h: begin
                    w_stage_duty_nxt[15:8] = spi.rx_byte;
                    w_pending_nxt          = 1'b1;
                end
                default: ;
            endcase
        end
        w_commit = w_pending_nxt & (~r_ctrl_en | pwm_period_end);
    end

    // Address pointer, direction and chip-select edge history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs_prev  <= 1'b1;
            r_addr     <= 3'd0;
            r_is_write <= 1'b0;
        end else begin
            r_cs_prev <= spi.cs_active;
            if (w_cmd_byte) begin
                r_addr     <= spi.rx_byte[2:0];
                r_is_write <= spi.rx_byte[7];
            end else if (w_data_byte) begin
                r_addr     <= r_addr + 3'd1;
            end
        end
    end

    // CTRL, sticky error flag and start pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl_en   <= 1'b0;
            r_ctrl_ext  <= 1'b0;
            r_frame_err <= 1'b0;
            r_start     <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_ctrl_en  <= spi.rx_byte[c_ctrl_en];
                r_ctrl_ext <= spi.rx_byte[c_ctrl_ext_en];
            end
            if (w_err_set)
                r_frame_err <= 1'b1;
            else if (w_wr && (r_addr == c_addr_status))
                r_frame_err <= 1'b0;
            r_start <= w_spi_start | w_ext_start;
        end
    end

    // Staging registers and committed PWM settings
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage_per  <= c_period_rst;
            r_stage_duty <= c_duty_rst;
            r_period     <= c_period_rst;
            r_duty       <= c_duty_rst;
            r_pending    <= 1'b0;
        end else begin
            r_stage_per  <= w_stage_per_nxt;
            r_stage_duty <= w_stage_duty_nxt;
            r_pending    <= w_commit ? 1'b0 : w_pending_nxt;
            if (w_commit) begin
                r_period <= w_stage_per_nxt;
                r_duty   <= sat_duty(w_stage_duty_nxt, w_stage_per_nxt);
            end
        end
    end

    // Reply byte: meaningful only within read frames, zero elsewhere
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx <= 8'h00;
        end else if (!spi.cs_active) begin
            r_tx <= 8'h00;
        end else if (w_cmd_byte) begin
            r_tx <= (w_cmd_ok && !spi.rx_byte[7]) ? w_rd_data : 8'h00;
        end else if (w_data_byte) begin
            r_tx <= r_is_write ? 8'h00 : w_rd_data;
        end else if (r_state != ST_DATA) begin
            r_tx <= 8'h00;
        end
    end

    assign spi.tx_byte = r_tx;
    assign pwm_en      = r_ctrl_en;
    assign pwm_period  = r_period;
    assign pwm_duty    = r_duty;
    assign pwm_start   = r_start;
    assign frame_err   = r_frame_err;
endmodule
`default_nettype wire

// File: tb/tb_spi_pwm_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_pwm_ctrl
// Description : Scoreboard bench for spi_pwm_ctrl with a behavioural model
//               of the register map and frame protocol.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_spi_pwm_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pwm_start_ext = 1'b0;
    logic        pwm_period_end = 1'b0;
    logic        pwm_en, pwm_start, frame_err;
    logic [15:0] pwm_period, pwm_duty;

    spi_pwm_ctrl_if spi ();

    spi_pwm_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .spi            (spi),
        .pwm_start_ext  (pwm_start_ext),
        .pwm_period_end (pwm_period_end),
        .pwm_en         (pwm_en),
        .pwm_period     (pwm_period),
        .pwm_duty       (pwm_duty),
        .pwm_start      (pwm_start),
        .frame_err      (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  tx;
        logic        en;
        logic [15:0] per;
        logic [15:0] duty;
        logic        ferr;
    } snap_t;

    snap_t exp_q[$];
    bit    exp_start[int];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    logic  ev_seen = 1'b0;
    logic  chk_req = 1'b0;
    logic  stim_done = 1'b0;

    // ---------------- behavioural model ----------------
    logic [1:0]  m_ctrl;            // {ext_start_en, en}
    logic [15:0] m_sper, m_sduty, m_per, m_duty;
    logic        m_pend, m_ferr;
    logic        m_open, m_cmd_seen, m_abort, m_write;
    int          m_addr;
    logic [7:0]  m_tx;

    task automatic model_reset();
        m_ctrl = 2'b00;
        m_sper = 16'h00FF; m_per = 16'h00FF;
        m_sduty = 16'h0080; m_duty = 16'h0080;
        m_pend = 1'b0; m_ferr = 1'b0;
        m_open = 1'b0; m_cmd_seen = 1'b0; m_abort = 1'b0; m_write = 1'b0;
        m_addr = 0; m_tx = 8'h00;
        exp_start.delete();
    endtask

    function automatic logic [7:0] read_reg(input int a);
        case (a)
            0: return {6'd0, m_ctrl};
            1: return m_sper[7:0];
            2: return m_sper[15:8];
            3: return m_sduty[7:0];
            4: return m_sduty[15:8];
            5: return {5'd0, m_pend, m_ferr, m_ctrl[0]};
            6: return 8'hA5;
            default: return 8'h00;
        endcase
    endfunction

    task automatic commit();
        m_per  = m_sper;
        m_duty = (m_sduty > m_sper) ? m_sper : m_sduty;
        m_pend = 1'b0;
    endtask

    task automatic push_snap();
        snap_t s;
        s.tx = m_tx; s.en = m_ctrl[0]; s.per = m_per; s.duty = m_duty; s.ferr = m_ferr;
        exp_q.push_back(s);
    endtask

    task automatic write_reg(input int a, input logic [7:0] b, input logic old_en);
        case (a)
            0: begin
                m_ctrl = b[1:0];
                if (b[2] && (b[0] || old_en)) exp_start[cyc + 1] = 1'b1;
            end
            1: m_sper[7:0] = b;
            2: begin m_sper[15:8] = b; m_pend = 1'b1; end
            3: m_sduty[7:0] = b;
            4: begin m_sduty[15:8] = b; m_pend = 1'b1; end
            5: m_ferr = 1'b0;
            default: ;
        endcase
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic old_en;
        old_en = m_ctrl[0];
        if (!m_open) begin
            m_tx = 8'h00;
        end else if (!m_cmd_seen) begin
            m_cmd_seen = 1'b1;
            if (b[6:3] != 4'd0) begin
                m_abort = 1'b1; m_ferr = 1'b1; m_tx = 8'h00;
            end else begin
                m_write = b[7];
                m_addr  = int'(b[2:0]);
                m_tx    = m_write ? 8'h00 : read_reg(m_addr);
            end
        end else if (m_abort) begin
            m_tx = 8'h00;
        end else if (m_write) begin
            m_tx = 8'h00;
            write_reg(m_addr, b, old_en);
            m_addr = (m_addr + 1) % 8;
        end else begin
            m_addr = (m_addr + 1) % 8;
            m_tx   = read_reg(m_addr);
        end
        if (m_pend && !old_en) commit();
        push_snap();
        // EN cleared while a commit was pending: it lands one cycle later
        if (m_pend && !m_ctrl[0]) commit();
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive_byte(input logic [7:0] b);
        @(negedge clk);
        spi.rx_valid = 1'b1;
        spi.rx_byte  = b;
        model_byte(b);
        @(negedge clk);
        spi.rx_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic cs_on();
        @(negedge clk);
        spi.cs_active = 1'b1;
        m_open = 1'b1; m_cmd_seen = 1'b0; m_abort = 1'b0; m_tx = 8'h00;
    endtask

    task automatic cs_off();
        @(negedge clk);
        spi.cs_active = 1'b0;
        m_open = 1'b0; m_tx = 8'h00;
        @(negedge clk);
    endtask

    task automatic period_end();
        @(negedge clk);
        pwm_period_end = 1'b1;
        if (m_pend && m_ctrl[0]) commit();
        push_snap();
        @(negedge clk);
        pwm_period_end = 1'b0;
        @(negedge clk);
    endtask

    task automatic req_check();
        @(posedge clk); #1;
        push_snap();
        chk_req = 1'b1;
        @(posedge clk); #1;
        chk_req = 1'b0;
    endtask

    // Raise the external start and write CTRL so both requests reach the same edge
    task automatic ext_and_ctrl(input logic [7:0] ctrl_byte);
        cs_on();
        drive_byte(8'h80);
        @(negedge clk);
        pwm_start_ext = 1'b1;
        if (m_ctrl == 2'b11) exp_start[cyc + 3] = 1'b1;
        @(negedge clk);
        drive_byte(ctrl_byte);
        cs_off();
        pwm_start_ext = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // ---------------- event capture and monitor ----------------
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        ev_seen <= spi.rx_valid | pwm_period_end;
    end

    always @(negedge clk) begin
        if (ev_seen || chk_req) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard: DUT event at cycle %0d with no expected entry", cyc);
            end else begin
                snap_t e;
                e = exp_q.pop_front();
                if (spi.tx_byte !== e.tx || pwm_en !== e.en || pwm_period !== e.per ||
                    pwm_duty !== e.duty || frame_err !== e.ferr) begin
                    errors++;
                    $display("FAIL outputs @%0d: got tx=%h en=%b per=%h duty=%h ferr=%b, expected tx=%h en=%b per=%h duty=%h ferr=%b",
                             cyc, spi.tx_byte, pwm_en, pwm_period, pwm_duty, frame_err,
                             e.tx, e.en, e.per, e.duty, e.ferr);
                end
            end
        end
        if (pwm_start === 1'b1) begin
            checks++;
            if (exp_start.exists(cyc)) begin
                exp_start.delete(cyc);
            end else begin
                errors++;
                $display("FAIL pwm_start: pulse at cycle %0d, expected none", cyc);
            end
        end
        if (stim_done) begin
            checks++;
            if (exp_q.size() != 0 || exp_start.num() != 0) begin
                errors++;
                $display("FAIL leftover: %0d snapshots and %0d start pulses never seen, expected 0",
                         exp_q.size(), exp_start.num());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
        if (cyc > 90000) begin
            $display("FAIL watchdog: cycle %0d reached, expected completion before 90000", cyc);
            $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
            $fatal(1);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        spi.cs_active = 1'b0;
        spi.rx_valid  = 1'b0;
        spi.rx_byte   = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        req_check();

        // Staged write with EN=0 commits immediately
        cs_on();
        drive_byte(8'h81); drive_byte(8'h34); drive_byte(8'h12);
        drive_byte(8'h40); drive_byte(8'h00);
        cs_off();
        cs_on(); drive_byte(8'h05); drive_byte(8'h00); cs_off();

        // EN=1: commit deferred to period end
        cs_on(); drive_byte(8'h80); drive_byte(8'h01); cs_off();
        cs_on();
        drive_byte(8'h81); drive_byte(8'h00); drive_byte(8'h02);
        drive_byte(8'h00); drive_byte(8'h01);
        cs_off();
        cs_on(); drive_byte(8'h05); drive_byte(8'h00); cs_off();
        period_end();
        cs_on(); drive_byte(8'h05); drive_byte(8'h00); cs_off();

        // ID, reserved, and wrap-around burst
        cs_on(); drive_byte(8'h06); drive_byte(8'h00); drive_byte(8'h00); cs_off();
        cs_on(); drive_byte(8'h07); drive_byte(8'h00); drive_byte(8'h00); cs_off();

        // Bad command aborts the frame; STATUS write clears the flag
        cs_on(); drive_byte(8'h48); drive_byte(8'h80); drive_byte(8'h00); cs_off();
        cs_on(); drive_byte(8'h05); drive_byte(8'h00); cs_off();
        cs_on(); drive_byte(8'h85); drive_byte(8'h00); cs_off();

        // Coincident SPI and external starts, then both with EN=0
        cs_on(); drive_byte(8'h80); drive_byte(8'h03); cs_off();
        ext_and_ctrl(8'h07);
        cs_on(); drive_byte(8'h80); drive_byte(8'h02); cs_off();
        ext_and_ctrl(8'h04);

        // Duty saturation
        cs_on(); drive_byte(8'h80); drive_byte(8'h00); cs_off();
        cs_on();
        drive_byte(8'h81); drive_byte(8'h00); drive_byte(8'h01);
        drive_byte(8'h00); drive_byte(8'h03);
        cs_off();

        // Reset mid-frame; following bytes ignored until cs reasserts
        cs_on(); drive_byte(8'h81); drive_byte(8'h55);
        @(negedge clk); rst_n = 1'b0;
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        req_check();
        drive_byte(8'h00); drive_byte(8'h66);
        cs_off();
        cs_on(); drive_byte(8'h01); drive_byte(8'h00); cs_off();

        // Randomized frames
        for (int f = 0; f < 150; f++) begin
            if ($urandom_range(0, 9) == 0) begin
                period_end();
            end else begin
                logic [7:0] cmd;
                cmd = 8'($urandom);
                if ($urandom_range(0, 7) != 0) cmd[6:3] = 4'd0;
                cs_on();
                drive_byte(cmd);
                for (int k = 0; k < int'($urandom_range(0, 4)); k++)
                    drive_byte(8'($urandom));
                cs_off();
            end
        end

        repeat (5) @(negedge clk);
        stim_done = 1'b1;
    end
endmodule
`default_nettype wire

// File: doc/spi_pwm_ctrl.md
SPI_PWM_CTRL -- requirements
Module: spi_pwm_ctrl

Interface
REQ-001 ID_VALUE, 8'hA5, constant returned by read-only ID register.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 cs_active  input  1  high while SPI chip-select is asserted; already synchronised to clk.
REQ-005 rx_valid  input  1  one-cycle strobe; rx_byte is valid.
REQ-006 rx_byte  input  8  byte received from SPI slave.
REQ-007 tx_byte  output  8  byte the SPI slave shifts out in the next byte slot.
REQ-008 pwm_start_ext  input  1  external start request; asynchronous to clk.
REQ-009 pwm_period_end  input  1  one-cycle pulse from PWM core on the last count of a period.
REQ-010 pwm_en  output  1  PWM core enable.
REQ-011 pwm_period  output  16  active period.
REQ-012 pwm_duty  output  16  active duty.
REQ-013 pwm_start  output  1  one-cycle start pulse to PWM core.
REQ-014 frame_err  output  1  sticky protocol-error flag.

Function
REQ-015 FSM states IDLE, CMD, DATA, ABORT; cs_active low in any state -> IDLE on next edge.
REQ-016 IDLE -> CMD only on a cs_active rising edge; cs edge-detect register resets to 1, so a frame already in progress at reset is ignored until cs deasserts and reasserts.
REQ-017 CMD, rx_valid: bit7 = 1 write / 0 read; bits[2:0] = start address; bits[6:3] nonzero -> set frame_err, go to ABORT, which ignores all bytes until cs low.
REQ-018 DATA, each rx_valid: write frames write rx_byte to the current address; address then increments mod 8 (7 wraps to 0).
REQ-019 Read frames: tx_byte = reg[addr] one cycle after the command byte; after each DATA rx_valid, tx_byte = reg[addr+1 mod 8]; write frames and IDLE drive tx_byte = 0.
REQ-020 Register map: 0 CTRL {bit0 EN, bit1 EXT_START_EN, bit2 START}; 1 PER_L; 2 PER_H; 3 DUTY_L; 4 DUTY_H; 5 STATUS; 6 ID; 7 reserved.
REQ-021 START is write-1 self-clearing and always reads 0; reserved reads 0; writes to ID and reserved are ignored.
REQ-022 STATUS reads {5'b0, pending, frame_err, pwm_en}; any write to STATUS clears frame_err; if a new error occurs in the same cycle, the error wins.
REQ-023 Writes to addr 1-4 go to staging registers; writes to addr 2 or 4 set pending.
REQ-024 Commit copies staging to pwm_period/pwm_duty and clears pending: immediately on the next cycle if EN = 0, otherwise on pwm_period_end.
REQ-025 At commit, a staged duty greater than the staged period saturates pwm_duty to the period value.
REQ-026 Register writes take effect the cycle after rx_valid; pwm_en follows CTRL.EN with the same latency.
REQ-027 pwm_start pulses one cycle after a CTRL write with START = 1 and EN = 1 in the written byte or already set.
REQ-028 pwm_start also pulses on a synchronised rising edge of pwm_start_ext when EN and EXT_START_EN are set; latency 3 cycles from input rise.
REQ-029 SPI and external starts in the same cycle produce a single pulse; start requests with EN = 0 are dropped.

Reset
REQ-030 Reset values: state IDLE; CTRL 0; pwm_en 0; pwm_period and staged period 16'h00FF; pwm_duty and staged duty 16'h0080; pending 0; frame_err 0; tx_byte 0; pwm_start 0; synchroniser flops 0.
REQ-031 Reset mid-frame aborts the frame without a partial register write.

Structure
REQ-032 Package spi_pwm_pkg holds: register address constants, CTRL bit indices, FSM state enum, period/duty reset constants.
REQ-033 Sub-module sync_rise (two-flop synchroniser plus rising-edge detect) handles pwm_start_ext.

Verification
REQ-034 Write frame 0x81,0x34,0x12,0x40,0x00 with EN = 0 -> pwm_period 0x1234, pwm_duty 0x0040, pending 0 one cycle after the last byte.
REQ-035 EN = 1, write PER 0x0200 / DUTY 0x0100 -> outputs unchanged and STATUS = 0x05 until pwm_period_end, then updated and STATUS = 0x01.
REQ-036 Read frame 0x06, dummy byte -> tx_byte 0xA5 after the command byte, then 0x00 (reserved); burst from 0x07 wraps address to 0 and returns CTRL.
REQ-037 Command byte 0x48 -> frame_err = 1, following bytes ignored; write to STATUS clears frame_err.
REQ-038 CTRL = 0x03, pwm_start_ext pulsed and CTRL write 0x07 in the same cycle window -> exactly one pwm_start; with EN = 0 -> no pulse.
REQ-039 Staged duty 0x0300 with period 0x0100 -> pwm_duty 0x0100 after commit; rst_n low mid-frame -> all reset values, and the remaining bytes are ignored until cs reasserts.
